// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result stream bundle for pipelined_adder
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, err
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, err
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep ripple-carry adder/subtractor, one CHUNK per clock, global stall
// Define PIPELINED_ADDER_DMR_EN to add a duplicate chunk adder per stage with a per-beat mismatch flag.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int IN_W = WIDTH - LO;
        localparam int DONE = LO + CHUNK;

        // a_in/b_in hold the operand bits from chunk k upward; chunk k sits at bit 0
        logic [IN_W-1:0] a_in;
        logic [IN_W-1:0] b_in;
        logic            c_in;
        logic            v_in;
        logic [CHUNK:0]  chunk_sum;
        logic [DONE-1:0] sum_d;
        logic [DONE-1:0] sum_q;
        logic            carry_q;
        logic            valid_q;

        if (k == 0) begin : g_src
            assign a_in  = bus.a;
            assign b_in  = bus.sub ? ~bus.b : bus.b;
            assign c_in  = bus.sub | bus.cin;
            assign v_in  = bus.in_valid;
            assign sum_d = chunk_sum[CHUNK-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_rem_q;
            assign b_in  = g_stage[k-1].g_fwd.b_rem_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign sum_d = {chunk_sum[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        assign chunk_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_in};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= v_in;
                carry_q <= chunk_sum[CHUNK];
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-CHUNK-1:0] a_rem_q;
            logic [IN_W-CHUNK-1:0] b_rem_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_rem_q <= '0;
                    b_rem_q <= '0;
                end else if (advance) begin
                    a_rem_q <= a_in[IN_W-1:CHUNK];
                    b_rem_q <= b_in[IN_W-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // carry into the MSB is a^b^s at that bit; compare with the carry out of it
            assign ovf_d = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end

`ifdef PIPELINED_ADDER_DMR_EN
        logic [CHUNK:0] dup_sum;
        logic           err_d;
        logic           err_q;

        assign dup_sum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, c_in};

        if (k == 0) begin : g_err
            assign err_d = (dup_sum != chunk_sum);
        end else begin : g_err
            assign err_d = g_stage[k-1].err_q | (dup_sum != chunk_sum);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (advance) begin
                err_q <= err_d;
            end
        end
`endif
    end

    assign advance       = !g_stage[STAGES-1].valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.s         = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
`ifdef PIPELINED_ADDER_DMR_EN
    assign bus.err       = g_stage[STAGES-1].err_q;
`else
    assign bus.err       = 1'b0;
`endif
endmodule
